mix_columns_seq: RTL

- Multi-cycle, parametrised AES MixColumns / InvMixColumns engine with valid/ready handshakes on input and output.
- Sits between the ShiftRows and AddRoundKey stages of the round datapath. Supports both the encrypt and decrypt datapaths.
- Processes COLS_PER_CYCLE 32-bit columns per clock, so area/latency is traded by parameter.
- Keeps the enable/bypass semantics of the existing combinational column mixer (enable=0 passes the state through unchanged).

---
 rtl/mix_columns_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mix_columns_seq.sv
// Multi-cycle AES MixColumns / InvMixColumns engine with valid/ready handshakes.
// Transforms COLS_PER_CYCLE columns per BUSY cycle in place; enable=0 bypasses the state.
module mix_columns_seq #(
   parameter int unsigned NCOL           = 4,
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                enable,
   input  logic                inv,
   input  logic [32*NCOL-1:0]  a,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*NCOL-1:0]  y,
   output logic                busy
);

   localparam int unsigned W    = 32 * NCOL;
   localparam int unsigned NGRP = NCOL / COLS_PER_CYCLE;
   localparam int unsigned CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

   if (COLS_PER_CYCLE < 1 || (NCOL % COLS_PER_CYCLE) != 0) begin : g_param_chk
      $error("mix_columns_seq: COLS_PER_CYCLE must divide NCOL");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    work_q, work_d;
   logic [W-1:0]    y_q, y_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            inv_q, inv_d;
   logic            accept;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Inverse = forward mix applied after the {05 00 04 00} circulant pre-step,
   // so both directions share one forward network.
   function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv_m);
      logic [7:0]  s [4];
      logic [7:0]  u, v;
      logic [31:0] r;
      u = '0;
      v = '0;
      r = '0;
      for (int unsigned i = 0; i < 4; i++) s[i] = c[31-8*i -: 8];
      if (inv_m) begin
         u = xt(xt(s[0] ^ s[2]));
         v = xt(xt(s[1] ^ s[3]));
         s[0] = s[0] ^ u;
         s[1] = s[1] ^ v;
         s[2] = s[2] ^ u;
         s[3] = s[3] ^ v;
      end
      for (int unsigned i = 0; i < 4; i++) begin
         r[31-8*i -: 8] = xt(s[i]) ^ xt(s[(i+1)%4]) ^ s[(i+1)%4]
                          ^ s[(i+2)%4] ^ s[(i+3)%4];
      end
      return r;
   endfunction

   assign in_ready  = !reset && (state_q == IDLE);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign y         = y_q;

   always_comb begin
      int unsigned col;
      col     = 0;
      state_d = state_q;
      work_d  = work_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      inv_d   = inv_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               work_d = a;
               inv_d  = inv;
               cnt_d  = '0;
               if (enable) begin
                  state_d = BUSY;
               end else begin
                  y_d     = a;
                  state_d = DONE;
               end
            end
         end
         BUSY: begin
            for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
               col = 32'(cnt_q) * COLS_PER_CYCLE + k;
               work_d[W-1-32*col -: 32] = mix_col(work_q[W-1-32*col -: 32], inv_q);
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(NGRP - 1)) begin
               y_d     = work_d;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         work_q  <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         inv_q   <= inv_d;
      end
   end

endmodule
